// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller: walks DUTY toward a commanded target
// in fixed steps, one step every RATE+1 clocks.
module pwm_ramp_ctrl #(
  parameter int RATE_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [7:0]        CMD_TARGET,
  input  logic [7:0]        CMD_STEP,
  input  logic [RATE_W-1:0] CMD_RATE,
  input  logic              ABORT,
  output logic [7:0]        DUTY,
  output logic              HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        duty_q, duty_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [RATE_W-1:0] presc_q, presc_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [7:0]        tgt_q, tgt_d;
  logic [7:0]        step_q, step_d;

  logic       accept;
  logic [7:0] up_gap, dn_gap;
  logic [7:0] up_nxt, dn_nxt;

  assign CMD_READY = (state_q == IDLE) && !ABORT;
  assign accept    = CMD_VALID && CMD_READY;

  // Gap compare clamps to the target, so the sum never wraps
  assign up_gap = tgt_q - duty_q;
  assign dn_gap = duty_q - tgt_q;
  assign up_nxt = (up_gap <= step_q) ? tgt_q : duty_q + step_q;
  assign dn_nxt = (dn_gap <= step_q) ? tgt_q : duty_q - step_q;

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    presc_d   = presc_q;
    rate_d    = rate_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = CMD_TARGET;
          step_d  = (CMD_STEP == 8'd0) ? 8'd1 : CMD_STEP;
          rate_d  = CMD_RATE;
          presc_d = CMD_RATE;
          if (CMD_TARGET > duty_q) begin
            state_d = UP;
          end else if (CMD_TARGET < duty_q) begin
            state_d = DOWN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      UP, DOWN: begin
        if (ABORT) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (presc_q == '0) begin
          presc_d = rate_q;
          duty_d  = (state_q == UP) ? up_nxt : dn_nxt;
          if (duty_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    hold_d = (duty_d == 8'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      duty_q    <= 8'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      presc_q   <= '0;
      rate_q    <= '0;
      tgt_q     <= 8'd0;
      step_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      presc_q   <= presc_d;
      rate_q    <= rate_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
    end
  end

  assign DUTY    = duty_q;
  assign HOLD    = hold_q;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign ABORTED = aborted_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramps plus random commands,
// checked against an arithmetic ramp model every cycle.
module tb_pwm_ramp_ctrl;

  localparam int RW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [7:0]    CMD_TARGET;
  logic [7:0]    CMD_STEP;
  logic [RW-1:0] CMD_RATE;
  logic          ABORT;
  logic [7:0]    DUTY;
  logic          HOLD;
  logic          BUSY;
  logic          DONE;
  logic          ABORTED;
  logic [1:0]    STATE;

  int compared = 0;
  int mismatched = 0;

  // Model: DUTY after k cycles = start +/- floor(k/(rate+1))*step, clamped
  bit in_ramp;
  bit up;
  int m_duty, m_tgt, m_stp, m_rate, start, k;
  bit e_done, e_ab;
  int done_cnt, ab_cnt;

  pwm_ramp_ctrl #(.RATE_W(RW)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TARGET(CMD_TARGET), .CMD_STEP(CMD_STEP),
    .CMD_RATE(CMD_RATE), .ABORT(ABORT),
    .DUTY(DUTY), .HOLD(HOLD), .BUSY(BUSY),
    .DONE(DONE), .ABORTED(ABORTED), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_ramp = 0; m_duty = 0; e_done = 0; e_ab = 0;
  endtask

  task automatic model_edge();
    int n;
    e_done = 0;
    e_ab = 0;
    if (in_ramp) begin
      k++;
      if (ABORT) begin
        in_ramp = 0;
        e_ab = 1;
      end else begin
        n = k / (m_rate + 1);
        if (up)
          m_duty = (start + n * m_stp > m_tgt) ? m_tgt : start + n * m_stp;
        else
          m_duty = (start - n * m_stp < m_tgt) ? m_tgt : start - n * m_stp;
        if (m_duty == m_tgt) begin
          in_ramp = 0;
          e_done = 1;
        end
      end
    end else if (CMD_VALID && !ABORT) begin
      m_tgt = CMD_TARGET;
      m_stp = (CMD_STEP == 0) ? 1 : CMD_STEP;
      m_rate = CMD_RATE;
      start = m_duty;
      if (m_tgt == m_duty) e_done = 1;
      else begin
        in_ramp = 1;
        up = (m_tgt > m_duty);
        k = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("duty", DUTY, m_duty);
    chk("state", STATE, in_ramp ? (up ? 1 : 2) : 0);
    chk("busy", BUSY, in_ramp);
    chk("hold", HOLD, m_duty == 0);
    chk("done", DONE, e_done);
    chk("aborted", ABORTED, e_ab);
    chk("ready", CMD_READY, !in_ramp && !ABORT);
    chk("done_and_aborted", DONE && ABORTED, 0);
    if (DONE === 1'b1) done_cnt++;
    if (ABORTED === 1'b1) ab_cnt++;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic cmd(input int t, input int s, input int r);
    CMD_VALID = 1; CMD_TARGET = 8'(t);
    CMD_STEP = 8'(s); CMD_RATE = RW'(r);
    cycle();
    CMD_VALID = 0;
  endtask

  // Run until the model finishes the ramp, then one extra cycle
  task automatic finish_ramp(input string tag, input int max_c);
    int c = 0;
    while (in_ramp && c < max_c) begin
      cycle();
      c++;
    end
    chk({tag, "_timeout"}, in_ramp, 0);
    cycle();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_duty"}, DUTY, 0);
    chk({tag, "_hold"}, HOLD, 1);
    chk({tag, "_state"}, STATE, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_aborted"}, ABORTED, 0);
  endtask

  initial begin
    int ab_at, t, s, r, c;
    RST = 1; CMD_VALID = 0; ABORT = 0;
    CMD_TARGET = 0; CMD_STEP = 0; CMD_RATE = 0;
    done_cnt = 0; ab_cnt = 0;
    model_reset();
    #1;
    reset_checks("rst");
    repeat (2) @(negedge CLK);
    reset_checks("rst_hold");
    RST = 0;
    cycle();

    // 0 -> 10, step 4, rate 2: 4,8,10 every 3 cycles
    done_cnt = 0;
    cmd(10, 4, 2);
    repeat (2) cycle();
    chk("r1_pre_step", DUTY, 0);
    cycle();
    chk("r1_first_step", DUTY, 4);
    chk("r1_hold_fell", HOLD, 0);
    finish_ramp("r1", 20);
    chk("r1_final", DUTY, 10);
    chk("r1_done_once", done_cnt, 1);

    // reach 200, then 200 -> 5 in steps of 100 at rate 0
    cmd(200, 255, 0);
    finish_ramp("to200", 5);
    done_cnt = 0;
    cmd(5, 100, 0);
    chk("r2_down", STATE, 2);
    cycle();
    chk("r2_step1", DUTY, 100);
    cycle();
    chk("r2_step2", DUTY, 5);
    cycle();
    chk("r2_done_once", done_cnt, 1);

    // step 0 means 1; no wrap at the top
    cmd(245, 255, 0);
    finish_ramp("to245", 5);
    cmd(250, 0, 0);
    finish_ramp("r3", 10);
    chk("r3_final", DUTY, 250);
    cmd(254, 255, 0);
    finish_ramp("to254", 5);
    cmd(255, 255, 0);
    finish_ramp("r3b", 5);
    chk("r3b_final", DUTY, 255);

    // abort on the cycle the prescaler reaches 0
    ab_cnt = 0; done_cnt = 0;
    cmd(0, 10, 3);
    repeat (7) cycle();
    chk("r4_pre_abort", DUTY, 245);
    ABORT = 1;
    cycle();
    ABORT = 0;
    chk("r4_frozen", DUTY, 245);
    chk("r4_idle", STATE, 0);
    cycle();
    chk("r4_ab_once", ab_cnt, 1);
    chk("r4_no_done", done_cnt, 0);

    // abort in idle blocks a command and does nothing else
    ABORT = 1; CMD_VALID = 1; CMD_TARGET = 100;
    CMD_STEP = 1; CMD_RATE = 0;
    cycle();
    ABORT = 0; CMD_VALID = 0;
    chk("r5_not_accepted", STATE, 0);
    chk("r5_ab_once", ab_cnt, 1);

    // target equal to current duty
    done_cnt = 0;
    cmd(245, 3, 1);
    chk("r6_stay_idle", STATE, 0);
    chk("r6_done", done_cnt, 1);
    cycle();

    // CMD_VALID held through a ramp with different parameters
    CMD_VALID = 1; CMD_TARGET = 100; CMD_STEP = 5; CMD_RATE = 1;
    cycle();
    CMD_TARGET = 50; CMD_STEP = 50; CMD_RATE = 0;
    c = 0;
    while (in_ramp && c < 100) begin
      cycle();
      c++;
    end
    chk("r7_timeout", in_ramp, 0);
    chk("r7_mid_target", DUTY, 100);
    cycle();
    CMD_VALID = 0;
    chk("r7_reaccept", STATE, 2);
    finish_ramp("r7b", 10);
    chk("r7b_final", DUTY, 50);

    // reset mid-ramp at 40
    cmd(0, 255, 0);
    finish_ramp("to0", 5);
    done_cnt = 0; ab_cnt = 0;
    cmd(100, 10, 0);
    repeat (4) cycle();
    chk("r8_at40", DUTY, 40);
    #2 RST = 1;
    #1;
    reset_checks("r8_rst");
    @(posedge CLK);
    @(negedge CLK);
    reset_checks("r8_rst_hold");
    RST = 0;
    model_reset();
    cycle();
    chk("r8_no_pulses", done_cnt + ab_cnt, 0);

    // random commands, occasional abort and stray CMD_VALID
    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 255);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 31);
      r = $urandom_range(0, 3);
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
      cmd(t, s, r);
      c = 0;
      while (in_ramp && c < 2000) begin
        c++;
        ABORT = (c == ab_at);
        CMD_VALID = $urandom_range(0, 1);
        CMD_TARGET = 8'($urandom);
        CMD_STEP = 8'($urandom);
        CMD_RATE = RW'($urandom_range(0, 3));
        cycle();
      end
      ABORT = 0; CMD_VALID = 0;
      chk("rand_timeout", in_ramp, 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
